// File: rtl/regfile_writeback_if.sv
// Writeback request channel: ALU result plus valid/ready handshake into regfile_writeback.
interface regfile_writeback_if;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [5:0]  FuncCode;

    modport master (output wb_valid, WriteReg, WriteData, FuncCode, input wb_ready);
    modport slave  (input wb_valid, WriteReg, WriteData, FuncCode, output wb_ready);
endinterface

// File: rtl/regfile_writeback.sv
// Writeback stage: ALU results queue in a small FIFO and commit one per cycle into a 32x32 register file.
// Define WB_BYPASS_EN to forward pending queue entries onto the A/B read ports.
module regfile_writeback #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic               CLK,
    input  logic               RESET,
    regfile_writeback_if.slave wb,
    input  logic               hold,
    input  logic [4:0]         ReadReg1,
    input  logic [4:0]         ReadReg2,
    output logic [31:0]        A,
    output logic [31:0]        B,
    output logic               commit_valid,
    output logic [4:0]         commit_reg,
    output logic [31:0]        commit_data,
    output logic [CNT_W-1:0]   write_count,
    output logic [CNT_W-1:0]   drop_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_Q = $clog2(DEPTH + 1);

    logic [31:0]      regs   [32];
    logic [4:0]       q_reg  [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_Q-1:0] count;

    logic legal_funct;
    logic accept;
    logic push;
    logic pop;

    // Only the R-type ALU ops that produce a register result are committed.
    assign legal_funct = wb.FuncCode inside {6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
    assign wb.wb_ready = (count < CNT_Q'(DEPTH));
    assign accept      = wb.wb_valid && wb.wb_ready;
    assign push        = accept && legal_funct;
    assign pop         = !hold && (count != '0);

    // NOTE: queue payload has no reset; count and the pointers qualify every
    // read of it, so stale contents are never observed. REGS is architecturally
    // visible and is cleared below.
    always_ff @(posedge CLK) begin
        if (push) begin
            q_reg[tail]  <= wb.WriteReg;
            q_data[tail] <= wb.WriteData;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
            commit_reg   <= '0;
            commit_data  <= '0;
            write_count  <= '0;
            drop_count   <= '0;
        end else begin
            commit_valid <= pop;
            if (pop) begin
                regs[q_reg[head]] <= q_data[head];
                commit_reg        <= q_reg[head];
                commit_data       <= q_data[head];
                head              <= head + PTR_W'(1);
                if (write_count != '1) write_count <= write_count + CNT_W'(1);
            end
            if (push) tail <= tail + PTR_W'(1);
            if (accept && !legal_funct && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
            if (push && !pop)      count <= count + CNT_Q'(1);
            else if (!push && pop) count <= count - CNT_Q'(1);
        end
    end

`ifdef WB_BYPASS_EN
    // Walk oldest to youngest so the youngest matching entry overrides.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx = '0;
        A   = regs[ReadReg1];
        B   = regs[ReadReg2];
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CNT_Q'(i) < count) begin
                if (q_reg[idx] == ReadReg1) A = q_data[idx];
                if (q_reg[idx] == ReadReg2) B = q_data[idx];
            end
        end
    end
`else
    assign A = regs[ReadReg1];
    assign B = regs[ReadReg2];
`endif

endmodule
